// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: serial line in, byte + status out.
interface uart_rx_if;
  logic       Rx;
  logic       Read_Ack;
  logic [7:0] Data_received;
  logic       Data_Ready;
  logic       Rx_Busy;
  logic       Framing_Error;
  logic       Overrun_Error;

  // Receiver side: samples the line, presents bytes and status.
  modport master (
    input  Rx,
    input  Read_Ack,
    output Data_received,
    output Data_Ready,
    output Rx_Busy,
    output Framing_Error,
    output Overrun_Error
  );

  // Line driver / byte consumer side.
  modport slave (
    output Rx,
    output Read_Ack,
    input  Data_received,
    input  Data_Ready,
    input  Rx_Busy,
    input  Framing_Error,
    input  Overrun_Error
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, held-valid/ack output, framing and overrun flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic      clock,
  input  logic      reset_n,
  uart_rx_if.master bus
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          oerr_q, oerr_d;
  logic          rx_meta, rxs;

  // Two-flop synchroniser; the line idles high so both flops reset to 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.Rx;
      rxs     <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  // Next-state and datapath update; a good stop sample overrides a same-cycle ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    oerr_d  = oerr_q;

    if (bus.Read_Ack && ready_q) begin
      ready_d = 1'b0;
      oerr_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            ferr_d  = 1'b0;
            ready_d = 1'b1;
            if (ready_q && !bus.Read_Ack) begin
              oerr_d = 1'b1;
            end
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs; busy is decoded straight from the state register.
  assign bus.Data_received = data_q;
  assign bus.Data_Ready    = ready_q;
  assign bus.Framing_Error = ferr_q;
  assign bus.Overrun_Error = oerr_q;
  assign bus.Rx_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit, 20 ns clock.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;
  int   lat;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Start bit plus eight data bits, LSB first.
  task automatic send_head(input logic [7:0] b);
    bus.Rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = b[i];
      cycles(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_head(b);
    bus.Rx = 1'b1;
    cycles(CPB);
  endtask

  task automatic pulse_ack();
    bus.Read_Ack = 1'b1;
    @(negedge clock);
    bus.Read_Ack = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (bus.Data_Ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] b2b [3];
    int         cyc;
    n_vec = 0;
    n_err = 0;
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h5A;

    bus.Rx       = 1'b1;
    bus.Read_Ack = 1'b0;
    reset_n      = 1'b0;
    cycles(3);
    check("rst_data",  32'(bus.Data_received), 32'h00);
    check("rst_ready", 32'(bus.Data_Ready),    32'd0);
    check("rst_busy",  32'(bus.Rx_Busy),       32'd0);
    check("rst_ferr",  32'(bus.Framing_Error), 32'd0);
    check("rst_oerr",  32'(bus.Overrun_Error), 32'd0);
    reset_n = 1'b1;
    cycles(5);

    // Single 0xAA frame: latency and busy window.
    lat = -1;
    fork
      send_frame(8'hAA);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clock);
          if (i == 2)   check("aa_busy_c2",   32'(bus.Rx_Busy), 32'd0);
          if (i == 3)   check("aa_busy_c3",   32'(bus.Rx_Busy), 32'd1);
          if (i == 154) check("aa_busy_c154", 32'(bus.Rx_Busy), 32'd1);
          if (bus.Data_Ready) begin
            lat = i;
            check("aa_busy_end", 32'(bus.Rx_Busy), 32'd0);
            break;
          end
        end
      end
    join
    check("aa_latency", 32'(lat >= 153 && lat <= 155), 32'd1);
    check("aa_data",    32'(bus.Data_received), 32'hAA);
    check("aa_ferr",    32'(bus.Framing_Error), 32'd0);
    pulse_ack();
    check("aa_ack",     32'(bus.Data_Ready), 32'd0);
    cycles(10);

    // Back-to-back frames with an ack after each.
    fork
      for (int k = 0; k < 3; k++) send_frame(b2b[k]);
      for (int k = 0; k < 3; k++) begin
        wait_ready(400, cyc);
        check("b2b_ready", 32'(cyc > 0), 32'd1);
        check("b2b_data",  32'(bus.Data_received), 32'(b2b[k]));
        check("b2b_ferr",  32'(bus.Framing_Error), 32'd0);
        check("b2b_oerr",  32'(bus.Overrun_Error), 32'd0);
        pulse_ack();
        check("b2b_ack",   32'(bus.Data_Ready), 32'd0);
      end
    join
    cycles(10);

    // Short low glitch is rejected at the start-bit midpoint.
    bus.Rx = 1'b0;
    cycles(4);
    check("gl_busy", 32'(bus.Rx_Busy), 32'd1);
    cycles(1);
    bus.Rx = 1'b1;
    cycles(25);
    check("gl_idle",  32'(bus.Rx_Busy),       32'd0);
    check("gl_ready", 32'(bus.Data_Ready),    32'd0);
    check("gl_ferr",  32'(bus.Framing_Error), 32'd0);
    check("gl_oerr",  32'(bus.Overrun_Error), 32'd0);

    // Bad stop bit followed by a held-low break, then a good frame.
    send_head(8'h3C);
    bus.Rx = 1'b0;
    cycles(CPB + 40);
    check("fe_ferr",  32'(bus.Framing_Error), 32'd1);
    check("fe_ready", 32'(bus.Data_Ready),    32'd0);
    check("fe_busy",  32'(bus.Rx_Busy),       32'd1);
    bus.Rx = 1'b1;
    cycles(4);
    check("fe_idle",  32'(bus.Rx_Busy),       32'd0);
    cycles(16);
    send_frame(8'h81);
    check("fe_nready", 32'(bus.Data_Ready),    32'd1);
    check("fe_ndata",  32'(bus.Data_received), 32'h81);
    check("fe_nferr",  32'(bus.Framing_Error), 32'd0);
    pulse_ack();
    cycles(5);

    // Overrun: second byte overwrites an unacknowledged first.
    send_frame(8'h11);
    send_frame(8'h22);
    check("ov_data",  32'(bus.Data_received), 32'h22);
    check("ov_ready", 32'(bus.Data_Ready),    32'd1);
    check("ov_oerr",  32'(bus.Overrun_Error), 32'd1);
    pulse_ack();
    check("ov_ack_ready", 32'(bus.Data_Ready),    32'd0);
    check("ov_ack_oerr",  32'(bus.Overrun_Error), 32'd0);
    check("ov_ack_data",  32'(bus.Data_received), 32'h22);
    cycles(5);

    // Reset in the middle of data bit 4 discards the partial byte.
    bus.Rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      bus.Rx = 1'(i % 2);
      cycles(CPB);
    end
    bus.Rx = 1'b1;
    cycles(CPB / 2);
    reset_n = 1'b0;
    cycles(2);
    check("mr_data",  32'(bus.Data_received), 32'h00);
    check("mr_ready", 32'(bus.Data_Ready),    32'd0);
    check("mr_busy",  32'(bus.Rx_Busy),       32'd0);
    check("mr_ferr",  32'(bus.Framing_Error), 32'd0);
    check("mr_oerr",  32'(bus.Overrun_Error), 32'd0);
    reset_n = 1'b1;
    cycles(3 * CPB);
    check("mr_post_ready", 32'(bus.Data_Ready), 32'd0);
    send_frame(8'h99);
    check("mr_99_data",  32'(bus.Data_received), 32'h99);
    check("mr_99_ready", 32'(bus.Data_Ready),    32'd1);
    check("mr_99_ferr",  32'(bus.Framing_Error), 32'd0);
    check("mr_99_oerr",  32'(bus.Overrun_Error), 32'd0);

    // Ack landing on the stop-sample edge: new byte wins, no overrun.
    fork
      send_frame(8'h42);
      begin
        cycles(154);
        pulse_ack();
      end
    join
    check("co_data",  32'(bus.Data_received), 32'h42);
    check("co_ready", 32'(bus.Data_Ready),    32'd1);
    check("co_oerr",  32'(bus.Overrun_Error), 32'd0);
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
